spi_master_cfg: RTL and testbench

//  Parametrised SPI master; successor to the fixed-mode 32-bit master. Adds runtime

---
 rtl/spi_master_cfg.sv | 146 ++++++++++++++
 tb/tb_spi_master_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, programmable SCLK divider, bit order and slave select.
// One full-duplex DATA_W-bit word per accepted start pulse; a single shift register serves TX and RX.
module spi_master_cfg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned N_SS   = 4,
    parameter int unsigned DIV_W  = 8,
    localparam int unsigned AW    = (N_SS > 1) ? $clog2(N_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] d_in,
    input  logic [AW-1:0]     in_addr,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              MISO,
    output logic              s_clk,
    output logic              MOSI,
    output logic [N_SS-1:0]   cs_n,
    output logic [DATA_W-1:0] d_out,
    output logic              done,
    output logic              busy
);
    localparam int unsigned BCW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StDone} state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_cfg;
    logic [BCW-1:0]    bit_cnt;
    logic              trail;
    logic              cpol_cfg;
    logic              cpha_cfg;
    logic              lsb_cfg;

    logic [N_SS-1:0]   cs_dec;
    logic              first_bit;
    logic              out_bit;
    logic [DATA_W-1:0] shift_in;
    logic              div_hit;
    logic              last_bit;

    // Out-of-range addresses match no select, so the transfer runs with every cs_n high.
    always_comb begin
        cs_dec = '1;
        for (int i = 0; i < N_SS; i++) begin
            if (int'(in_addr) == i) cs_dec[i] = 1'b0;
        end
    end

    assign first_bit = lsb_first ? d_in[0] : d_in[DATA_W-1];
    assign out_bit   = lsb_cfg ? shreg[0] : shreg[DATA_W-1];
    assign shift_in  = lsb_cfg ? {MISO, shreg[DATA_W-1:1]} : {shreg[DATA_W-2:0], MISO};
    assign div_hit   = (div_cnt == div_cfg);
    assign last_bit  = (bit_cnt == BCW'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            shreg    <= '0;
            div_cnt  <= '0;
            div_cfg  <= '0;
            bit_cnt  <= '0;
            trail    <= 1'b0;
            cpol_cfg <= 1'b0;
            cpha_cfg <= 1'b0;
            lsb_cfg  <= 1'b0;
            s_clk    <= 1'b0;
            MOSI     <= 1'b0;
            cs_n     <= '1;
            d_out    <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    s_clk <= cpol;
                    cs_n  <= '1;
                    if (start) begin
                        state    <= StSetup;
                        shreg    <= d_in;
                        div_cfg  <= clk_div;
                        div_cnt  <= '0;
                        cpol_cfg <= cpol;
                        cpha_cfg <= cpha;
                        lsb_cfg  <= lsb_first;
                        cs_n     <= cs_dec;
                        busy     <= 1'b1;
                        if (!cpha) MOSI <= first_bit;
                    end
                end
                StSetup: begin
                    if (div_hit) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        trail   <= 1'b0;
                        state   <= StXfer;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StXfer: begin
                    if (div_hit) begin
                        div_cnt <= '0;
                        s_clk   <= ~s_clk;
                        trail   <= ~trail;
                        if (!trail) begin
                            if (!cpha_cfg) shreg <= shift_in;
                            else           MOSI  <= out_bit;
                        end else begin
                            // The final trailing edge must not disturb MOSI during HOLD.
                            if (cpha_cfg)       shreg <= shift_in;
                            else if (!last_bit) MOSI  <= out_bit;
                            if (last_bit) state   <= StHold;
                            else          bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StHold: begin
                    s_clk <= cpol_cfg;
                    if (div_hit) begin
                        div_cnt <= '0;
                        state   <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        d_out   <= shreg;
                        cs_n    <= '1;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: directed transfers, expected words queued at issue and checked by a
// separate done monitor; per-transfer timing, select, clock and MOSI checks in the driver.
module tb_spi_master_cfg;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] d_in = '0;
    logic [1:0] in_addr = '0;
    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    logic       lsb_first = 1'b0;
    logic [7:0] clk_div = '0;
    logic       MISO;
    logic       s_clk, MOSI, done, busy;
    logic [3:0] cs_n;
    logic [7:0] d_out;
    logic       s_clk2, mosi2, done2, busy2;
    logic [2:0] cs_n2;
    logic [7:0] d_out2;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_q[$];
    int         done_cnt = 0;
    int         exp_dones = 0;

    int         miso_mode = 0;  // 0 loopback, 1 constant one, 2 slave shift register
    logic [7:0] slv_data = '0;
    int         slv_idx = 0;
    logic       slv_bit = 1'b0;
    bit         watch = 1'b0;
    bit         cpol_cur = 1'b0;
    bit         cpha_cur = 1'b0;
    int         edges = 0;
    int         rises = 0;
    logic [7:0] mosi_seq = '0;

    assign MISO = (miso_mode == 0) ? MOSI : (miso_mode == 1) ? 1'b1 : slv_bit;

    spi_master_cfg #(.DATA_W(8), .N_SS(4), .DIV_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .d_in(d_in), .in_addr(in_addr), .cpol(cpol),
        .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .MISO(MISO), .s_clk(s_clk),
        .MOSI(MOSI), .cs_n(cs_n), .d_out(d_out), .done(done), .busy(busy)
    );

    // Three selects, so in_addr == 3 is out of range for this instance.
    spi_master_cfg #(.DATA_W(8), .N_SS(3), .DIV_W(8)) dut3 (
        .clk(clk), .rst(rst), .start(start), .d_in(d_in), .in_addr(in_addr), .cpol(cpol),
        .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div), .MISO(MISO), .s_clk(s_clk2),
        .MOSI(mosi2), .cs_n(cs_n2), .d_out(d_out2), .done(done2), .busy(busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave view of the bus: collect MOSI on master sample edges, drive MISO on the others.
    always @(s_clk) begin
        if (watch) begin
            edges++;
            if (s_clk) rises++;
            if ((s_clk != cpol_cur) ^ cpha_cur) begin
                mosi_seq = {mosi_seq[6:0], MOSI};
            end else if (miso_mode == 2) begin
                slv_bit = slv_data[slv_idx];
                slv_idx++;
            end
        end
    end

    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got d_out 0x%0h expected no done", d_out);
                end else begin
                    e = exp_q.pop_front();
                    check("d_out", d_out, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic start_xfer(input logic [7:0] d, input logic [1:0] a, input bit pol,
                              input bit pha, input bit lsb, input logic [7:0] div,
                              input logic [7:0] exp_rx);
        @(negedge clk);
        d_in = d; in_addr = a; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
        start = 1'b1;
        cpol_cur = pol; cpha_cur = pha;
        edges = 0; rises = 0; mosi_seq = '0; slv_idx = 0;
        exp_q.push_back(exp_rx);
        exp_dones++;
        @(posedge clk);
    endtask

    task automatic watch_xfer(input int h, input logic [3:0] ecs, input logic [2:0] ecs2,
                              input logic [7:0] etx, input bit ign);
        int   last;
        int   done_cyc;
        int   first_tog;
        int   cs_bad;
        int   cs2_bad;
        int   busy_bad;
        bit   in_x;
        logic mosi1;
        last = 18 * h;
        done_cyc = -1; first_tog = -1; cs_bad = 0; cs2_bad = 0; busy_bad = 0; mosi1 = 1'b0;
        for (int c = 1; c <= last + 20 && done_cyc < 0; c++) begin
            @(negedge clk);
            watch = 1'b1;
            if (ign && (c == 5 || c == 10)) begin
                start = 1'b1;
                d_in = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (c == 1) mosi1 = MOSI;
            if (first_tog < 0 && s_clk != cpol_cur) first_tog = c;
            in_x = (c <= last);
            if (cs_n != (in_x ? ecs : 4'hF)) cs_bad++;
            if (cs_n2 != (in_x ? ecs2 : 3'h7)) cs2_bad++;
            if (busy != in_x) busy_bad++;
            if (done) done_cyc = c;
        end
        watch = 1'b0;
        start = 1'b0;
        check("done_cycle", done_cyc, last + 1);
        check("cs_n_window", cs_bad, 0);
        check("cs_n_n3_window", cs2_bad, 0);
        check("busy_window", busy_bad, 0);
        check("first_sclk_toggle", first_tog, 2 * h + 1);
        check("sclk_edges", edges, 16);
        check("sclk_rises", rises, 8);
        check("mosi_bits", mosi_seq, etx);
        if (!cpha_cur) check("mosi_cycle1", mosi1, etx[7]);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_cs_n", cs_n, 4'hF);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_s_clk", s_clk, 0);
        check("rst_mosi", MOSI, 0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_d_out", d_out, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // Mode 0, H=1, MSB first, loopback: word returns unchanged
        miso_mode = 0;
        start_xfer(8'hA5, 2'd0, 0, 0, 0, 8'd0, 8'hA5);
        watch_xfer(1, 4'b1110, 3'b110, 8'hA5, 0);

        cpol = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol1", s_clk, 1);

        // Mode 3, H=4, MISO tied high
        miso_mode = 1;
        start_xfer(8'h3C, 2'd1, 1, 1, 0, 8'd3, 8'hFF);
        watch_xfer(4, 4'b1101, 3'b101, 8'h3C, 0);

        // Mode 1, LSB first: MOSI sends 1 then zeros; slave returns 0x80 LSB first
        miso_mode = 2;
        slv_data = 8'h80;
        start_xfer(8'h01, 2'd2, 0, 1, 1, 8'd0, 8'h80);
        watch_xfer(1, 4'b1011, 3'b011, 8'h80, 0);

        // Mode 2, H=2, address 3: in range for N_SS=4, out of range for N_SS=3
        miso_mode = 0;
        start_xfer(8'hC3, 2'd3, 1, 0, 0, 8'd1, 8'hC3);
        watch_xfer(2, 4'b0111, 3'b111, 8'hC3, 0);

        // Starts during the transfer (with a changed d_in) must be ignored
        start_xfer(8'h96, 2'd0, 0, 0, 0, 8'd1, 8'h96);
        watch_xfer(2, 4'b1110, 3'b110, 8'h96, 1);
        repeat (60) @(negedge clk);
        check("no_queued_start", busy, 0);
        check("done_count", done_cnt, exp_dones);

        // Reset in the middle of XFER
        start_xfer(8'hA5, 2'd1, 0, 0, 0, 8'd1, 8'h00);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        exp_q.delete();
        exp_dones--;
        check("midrst_s_clk", s_clk, 0);
        check("midrst_mosi", MOSI, 0);
        check("midrst_cs_n", cs_n, 4'hF);
        check("midrst_d_out", d_out, 0);
        check("midrst_done", done, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;

        start_xfer(8'h5A, 2'd0, 0, 0, 0, 8'd0, 8'h5A);
        watch_xfer(1, 4'b1110, 3'b110, 8'h5A, 0);
        repeat (4) @(negedge clk);
        check("final_done_count", done_cnt, exp_dones);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
